// File: rtl/bnn_xnor_accum.sv
// Multi-word XNOR-popcount neuron with threshold activation and valid/ready handshakes.
// Optional bipolar signed sum: define BNN_SIGNED_SUM_EN.
module bnn_xnor_accum #(
    parameter int DATA_W = 32,
    parameter int WC_W   = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [31:0]       cfg_data,
    input  logic              thr_we,
    input  logic [CNT_W-1:0]  thr_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] xor_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_act,
    output logic [CNT_W-1:0]  out_count,
    output logic              busy
);
    localparam int ACT_W = $clog2(DATA_W + 1);

    typedef enum logic {ACC, OUT} state_t;

    state_t           state;
    logic [ACT_W-1:0] active_bits;
    logic [WC_W-1:0]  words;
    logic [WC_W-1:0]  cnt;
    logic [CNT_W-1:0] threshold;
    logic [CNT_W-1:0] acc;

    logic             idle;
    logic             accept;
    logic             last;
    logic [ACT_W-1:0] mism;
    logic [ACT_W-1:0] match;
    logic [CNT_W:0]   sum;
    logic [CNT_W-1:0] acc_next;
    logic [CNT_W-1:0] res;
    logic             act;
    logic [ACT_W-1:0] cfg_ab;
    logic [WC_W-1:0]  cfg_w;
    logic             unused_cfg;

    assign unused_cfg = ^{cfg_data[31:16+WC_W], cfg_data[15:ACT_W]};

    assign idle   = (state == ACC) && (cnt == '0);
    assign accept = in_valid && in_ready;
    assign last   = (cnt == words - 1'b1);
    assign busy   = (cnt != '0) || out_valid;

    // Config/threshold writes win over a beat only at the start of a neuron.
    always_comb begin
        in_ready = 1'b0;
        if (!reset && state == ACC)
            in_ready = (cnt != '0) || !(cfg_we || thr_we);
    end

    always_comb begin
        mism = '0;
        for (int unsigned i = 0; i < DATA_W; i++)
            if (ACT_W'(i) < active_bits && xor_in[i])
                mism = mism + 1'b1;
        match    = active_bits - mism;
        sum      = {1'b0, acc} + (CNT_W+1)'(match);
        acc_next = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    end

`ifdef BNN_SIGNED_SUM_EN
    logic [ACT_W+WC_W-1:0] prod;
    always_comb begin
        prod = (ACT_W+WC_W)'(active_bits) * (ACT_W+WC_W)'(words);
        res  = {acc_next[CNT_W-2:0], 1'b0} - CNT_W'(prod);
        act  = $signed(res) >= $signed(threshold);
    end
`else
    always_comb begin
        res = acc_next;
        act = res >= threshold;
    end
`endif

    always_comb begin
        cfg_ab = cfg_data[ACT_W-1:0];
        if (cfg_ab == '0 || cfg_ab > ACT_W'(DATA_W))
            cfg_ab = ACT_W'(DATA_W);
        cfg_w = cfg_data[16+WC_W-1:16];
        if (cfg_w == '0)
            cfg_w = WC_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ACC;
            out_valid   <= 1'b0;
            out_act     <= 1'b0;
            out_count   <= '0;
            active_bits <= ACT_W'(DATA_W);
            words       <= WC_W'(1);
            threshold   <= '0;
            acc         <= '0;
            cnt         <= '0;
        end else begin
            case (state)
                ACC: begin
                    if (idle && cfg_we) begin
                        active_bits <= cfg_ab;
                        words       <= cfg_w;
                    end
                    if (idle && thr_we)
                        threshold <= thr_data;
                    if (accept) begin
                        if (last) begin
                            out_count <= res;
                            out_act   <= act;
                            out_valid <= 1'b1;
                            state     <= OUT;
                            cnt       <= '0;
                            acc       <= '0;
                        end else begin
                            cnt <= cnt + 1'b1;
                            acc <= acc_next;
                        end
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ACC;
                    end
                end
                default: state <= ACC;
            endcase
        end
    end
endmodule

// File: tb/tb_bnn_xnor_accum.sv
// Scoreboard bench for bnn_xnor_accum: driver holds a behavioural model, monitor checks results.
// Define BNN_SIGNED_SUM_EN for the bipolar signed-sum build.
module tb_bnn_xnor_accum;
    localparam int DATA_W = 32;
    localparam int WC_W   = 8;
    localparam int CNT_W  = 12;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cfg_we = 1'b0;
    logic [31:0]       cfg_data = '0;
    logic              thr_we = 1'b0;
    logic [CNT_W-1:0]  thr_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] xor_in = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic              out_act;
    logic [CNT_W-1:0]  out_count;
    logic              busy;

    always #5 clk = ~clk;

    bnn_xnor_accum #(.DATA_W(DATA_W), .WC_W(WC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_data(cfg_data),
        .thr_we(thr_we), .thr_data(thr_data), .in_valid(in_valid),
        .in_ready(in_ready), .xor_in(xor_in), .out_valid(out_valid),
        .out_ready(out_ready), .out_act(out_act), .out_count(out_count),
        .busy(busy)
    );

    typedef struct { int count; bit act; } res_t;
    res_t q[$];

    int checks = 0;
    int passes = 0;

    // Reference model state
    int m_ab = 32, m_w = 1, m_thr = 0, m_cnt = 0, m_acc = 0;
    bit m_pend = 0;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    endtask

    function automatic res_t mk(input int a);
        res_t r;
`ifdef BNN_SIGNED_SUM_EN
        int c, sc, st;
        c  = (2 * a - m_ab * m_w) & CMAX;
        sc = (c > CMAX / 2) ? c - (CMAX + 1) : c;
        st = (m_thr > CMAX / 2) ? m_thr - (CMAX + 1) : m_thr;
        r.count = c;
        r.act   = (sc >= st);
`else
        r.count = a;
        r.act   = (a >= m_thr);
`endif
        return r;
    endfunction

    task automatic step(input bit r, input bit cw, input logic [31:0] cd,
                        input bit tw, input logic [CNT_W-1:0] td,
                        input bit iv, input logic [31:0] x, input bit ordy);
        bit idle, er;
        logic [63:0] mask;
        int ab, w;
        reset = r; cfg_we = cw; cfg_data = cd; thr_we = tw; thr_data = td;
        in_valid = iv; xor_in = x; out_ready = ordy;
        idle = !m_pend && m_cnt == 0;
        er   = !r && !m_pend && (m_cnt != 0 || !(cw || tw));
        @(negedge clk);
        chk("in_ready", in_ready, er);
        if (!r) begin
            chk("out_valid", out_valid, m_pend);
            chk("busy", busy, m_pend || m_cnt != 0);
        end
        @(posedge clk);
        if (r) begin
            m_ab = 32; m_w = 1; m_thr = 0; m_cnt = 0; m_acc = 0; m_pend = 0;
            q.delete();
        end else begin
            if (m_pend && ordy) m_pend = 0;
            if (idle && cw) begin
                ab = int'(cd[5:0]);
                w  = int'(cd[23:16]);
                m_ab = (ab == 0 || ab > DATA_W) ? DATA_W : ab;
                m_w  = (w == 0) ? 1 : w;
            end
            if (idle && tw) m_thr = int'(td);
            if (er && iv) begin
                mask  = (64'd1 << m_ab) - 64'd1;
                m_acc = m_acc + m_ab - $countones({32'd0, x} & mask);
                if (m_acc > CMAX) m_acc = CMAX;
                m_cnt++;
                if (m_cnt == m_w) begin
                    q.push_back(mk(m_acc));
                    m_pend = 1; m_cnt = 0; m_acc = 0;
                end
            end
        end
        #1;
    endtask

    task automatic idle_cyc(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic beat(input logic [31:0] x);
        step(0, 0, 0, 0, 0, 1, x, 1);
    endtask

    task automatic cfg(input int ab, input int w);
        step(0, 1, (w << 16) | ab, 0, 0, 0, 0, 1);
    endtask

    task automatic thr(input logic [CNT_W-1:0] t);
        step(0, 0, 0, 1, t, 0, 0, 1);
    endtask

    // Monitor: result must match the scoreboard head for every cycle it is presented
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_result: got count %0d act %0d expected none", out_count, out_act);
            end else begin
                chk("out_count", out_count, q[0].count);
                chk("out_act", out_act, q[0].act);
                if (out_ready) void'(q.pop_front());
            end
        end
    end

    localparam logic [31:0] B1 = 32'(9'b011001110 ^ 9'b101010101);
    localparam logic [31:0] B2 = 32'(9'b111100101 ^ 9'b101100111);

    initial begin
        logic [CNT_W-1:0] thr_list [4];
        thr_list[0] = 12'd10; thr_list[1] = 12'd11;
        thr_list[2] = 12'd3;  thr_list[3] = 12'hFFE;

        step(1, 0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 1, 0, 1);
        chk("rst_out_count", out_count, 0);
        chk("rst_out_act", out_act, 0);

        // defaults, single all-match word
        beat(32'h0);
        idle_cyc(2);

        // two-word 9-bit neuron with several thresholds
        for (int i = 0; i < 4; i++) begin
            thr(thr_list[i]);
            cfg(9, 2);
            beat(B1 | 32'hFFFF_FE00);
            beat(B2);
            idle_cyc(2);
        end

        // backpressure, then the beat offered on the handshake cycle
        beat(B1); beat(B2);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, B1, 0);
        step(0, 0, 0, 0, 0, 1, B1, 1);
        beat(B1); beat(B2);
        idle_cyc(2);

        // config write mid-neuron is dropped
        beat(B1);
        step(0, 1, (2 << 16) | 4, 1, 12'd0, 0, 0, 1);
        beat(B2);
        idle_cyc(2);

        // reset mid-neuron restores defaults
        beat(B1);
        step(1, 0, 0, 0, 0, 0, 0, 1);
        beat(32'hFFFF_FFFF);
        idle_cyc(2);

        // accumulator saturation
        cfg(32, 200);
        for (int i = 0; i < 200; i++) beat(32'h0);
        idle_cyc(2);

        // field clamping
        cfg(0, 0);
        beat(32'h0000_F0F0);
        idle_cyc(2);
        cfg(40, 1);
        beat(32'h1234_5678);
        idle_cyc(2);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 15) == 0,
                 (32'($urandom_range(0, 3)) << 16) | 32'($urandom_range(0, 40)),
                 $urandom_range(0, 15) == 0,
                 CNT_W'($urandom_range(0, 80)),
                 $urandom_range(0, 3) != 0,
                 $urandom,
                 $urandom_range(0, 2) != 0);
        end

        // bounded drain of any pending result
        for (int i = 0; i < 20 && (q.size() != 0 || m_pend); i++) idle_cyc(1);
        chk("drain_queue_empty", q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
